// File: rtl/nco_sched_if.sv
// Configuration, sincos and result signals of the time-multiplexed NCO scheduler.
// The slave modport is the scheduler side; master is the driver/sincos side.
interface nco_sched_if #(
  parameter int NCH = 4,
  parameter int PHW = 32
);
  localparam int CW = $clog2(NCH);

  logic           cfg_we;
  logic [CW-1:0]  cfg_ch;
  logic [PHW-1:0] cfg_ftw;
  logic           cfg_sync;
  logic [NCH-1:0] ch_en;
  logic           cfg_pend;
  logic [19:0]    sc_angle;
  logic [18:0]    sc_sin;
  logic [18:0]    sc_cos;
  logic           out_valid;
  logic [CW-1:0]  out_ch;
  logic [18:0]    out_sin;
  logic [18:0]    out_cos;

  modport master (
    output cfg_we, cfg_ch, cfg_ftw, cfg_sync, ch_en, sc_sin, sc_cos,
    input  cfg_pend, sc_angle, out_valid, out_ch, out_sin, out_cos
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_ftw, cfg_sync, ch_en, sc_sin, sc_cos,
    output cfg_pend, sc_angle, out_valid, out_ch, out_sin, out_cos
  );
endinterface

// File: rtl/nco_sched.sv
// Time-multiplexed NCO: one phase accumulator per channel, one sincos issue per clock,
// tuning words and phase sync committed only at frame boundaries.
module nco_sched_lane #(
  parameter int PHW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we_i,
  input  logic [PHW-1:0] ftw_i,
  input  logic           commit_i,
  input  logic           clr_i,
  input  logic           issue_i,
  output logic [19:0]    ang_o,
  output logic           pend_o
);
  logic [PHW-1:0] acc_q, acc_d, ftw_q, ftw_d, shd_q, shd_d;
  logic           pend_q, pend_d;

  always_comb begin
    acc_d  = acc_q;
    ftw_d  = ftw_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    if (issue_i) acc_d = acc_q + ftw_q;
    // Commit uses the shadow as it stood before this edge; a write landing
    // on the same edge becomes pending for the next frame.
    if (commit_i) begin
      if (pend_q) ftw_d = shd_q;
      pend_d = 1'b0;
      if (clr_i) acc_d = '0;
    end
    if (we_i) begin
      shd_d  = ftw_i;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      ftw_q  <= '0;
      shd_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ftw_q  <= ftw_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
    end
  end

  assign ang_o  = acc_q[PHW-1 -: 20];
  assign pend_o = pend_q;
endmodule

module nco_sched #(
  parameter int NCH    = 4,
  parameter int PHW    = 32,
  parameter int SC_LAT = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  nco_sched_if.slave  bus
);
  localparam int CW     = $clog2(NCH);
  localparam int STAGES = SC_LAT;

  logic [CW-1:0]            slot_q;
  logic                     wrap, issue_any;
  logic                     sync_q, sync_d;
  logic [NCH-1:0]           pend, lane_we, lane_iss;
  logic [NCH-1:0][19:0]     ang;
  logic [19:0]              angle_q, angle_d;
  // Stage 0 is aligned with sc_angle; stage STAGES with sc_sin/sc_cos.
  logic [STAGES:0]          vld_pipe;
  logic [STAGES:0][CW-1:0]  ch_pipe;
  logic                     out_valid_q;
  logic [CW-1:0]            out_ch_q;
  logic [18:0]              out_sin_q, out_cos_q;

  assign wrap      = (slot_q == CW'(NCH - 1));
  assign issue_any = bus.ch_en[slot_q];

  for (genvar i = 0; i < NCH; i++) begin : g_sel
    assign lane_we[i]  = bus.cfg_we && (bus.cfg_ch == CW'(i));
    assign lane_iss[i] = bus.ch_en[i] && (slot_q == CW'(i));
  end

  nco_sched_lane #(.PHW(PHW)) u_lane [NCH-1:0] (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (lane_we),
    .ftw_i    (bus.cfg_ftw),
    .commit_i (wrap),
    .clr_i    (sync_q),
    .issue_i  (lane_iss),
    .ang_o    (ang),
    .pend_o   (pend)
  );

  always_comb begin
    angle_d = angle_q;
    sync_d  = sync_q;
    if (issue_any) angle_d = ang[slot_q];
    if (wrap)      sync_d  = 1'b0;
    if (bus.cfg_sync) sync_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      angle_q     <= '0;
      sync_q      <= 1'b0;
      vld_pipe    <= '0;
      ch_pipe     <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_sin_q   <= '0;
      out_cos_q   <= '0;
    end else begin
      slot_q      <= slot_q + CW'(1);
      angle_q     <= angle_d;
      sync_q      <= sync_d;
      vld_pipe    <= {vld_pipe[STAGES-1:0], issue_any};
      ch_pipe     <= {ch_pipe[STAGES-1:0], slot_q};
      out_valid_q <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        out_ch_q  <= ch_pipe[STAGES];
        out_sin_q <= bus.sc_sin;
        out_cos_q <= bus.sc_cos;
      end
    end
  end

  assign bus.sc_angle  = angle_q;
  assign bus.cfg_pend  = (|pend) | sync_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_sin   = out_sin_q;
  assign bus.out_cos   = out_cos_q;
endmodule

// File: tb/tb_nco_sched.sv
// Directed bench for nco_sched: a behavioural frame model predicts every issued
// angle and queues the expected sincos result for exact-cycle comparison.
module tb_nco_sched;
  localparam int NCH = 4, PHW = 32, SC_LAT = 7, CW = $clog2(NCH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nco_sched_if #(.NCH(NCH), .PHW(PHW)) bus();
  nco_sched #(.NCH(NCH), .PHW(PHW), .SC_LAT(SC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));

  function automatic logic [18:0] fsin(input logic [19:0] a); return a[19:1]; endfunction
  function automatic logic [18:0] fcos(input logic [19:0] a); return a[18:0] ^ 19'h5A5A5; endfunction

  // Sincos stand-in with SC_LAT clocks of latency.
  logic [SC_LAT-1:0][19:0] scp = '0;
  always @(posedge clk) scp <= {scp[SC_LAT-2:0], bus.sc_angle};
  assign bus.sc_sin = fsin(scp[SC_LAT-1]);
  assign bus.sc_cos = fcos(scp[SC_LAT-1]);

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct { int ch; logic [19:0] ang; int due; } ent_t;
  ent_t sbq[$];
  ent_t ne, ce;

  int             m_slot = 0, cyc = 0;
  logic [PHW-1:0] m_acc[NCH], m_ftw[NCH], m_sh[NCH];
  bit             m_pend[NCH];
  bit             m_sync;
  logic [19:0]    m_ang;

  function automatic bit pend_any();
    bit r = m_sync;
    for (int i = 0; i < NCH; i++) r |= m_pend[i];
    return r;
  endfunction

  // Reference frame model, evaluated at each active edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_slot = 0; m_sync = 0; m_ang = '0;
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = '0; m_ftw[i] = '0; m_sh[i] = '0; m_pend[i] = 0;
      end
      sbq.delete();
    end else begin
      cyc++;
      if (bus.ch_en[m_slot]) begin
        ne.ch = m_slot; ne.ang = m_acc[m_slot][PHW-1 -: 20]; ne.due = cyc + 1 + SC_LAT;
        sbq.push_back(ne);
        m_ang = ne.ang;
        m_acc[m_slot] = m_acc[m_slot] + m_ftw[m_slot];
      end
      if (m_slot == NCH - 1) begin
        for (int i = 0; i < NCH; i++) begin
          if (m_sync) m_acc[i] = '0;
          if (m_pend[i]) m_ftw[i] = m_sh[i];
          m_pend[i] = 0;
        end
        m_sync = 0;
      end
      if (bus.cfg_we) begin m_sh[bus.cfg_ch] = bus.cfg_ftw; m_pend[bus.cfg_ch] = 1; end
      if (bus.cfg_sync) m_sync = 1;
      m_slot = (m_slot + 1) % NCH;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("sc_angle", 64'(bus.sc_angle), 64'(m_ang));
      chk("cfg_pend", 64'(bus.cfg_pend), 64'(pend_any()));
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        ce = sbq.pop_front();
        chk("out_valid", 64'(bus.out_valid), 64'(1));
        chk("out_ch", 64'(bus.out_ch), 64'(ce.ch));
        chk("out_sin", 64'(bus.out_sin), 64'(fsin(ce.ang)));
        chk("out_cos", 64'(bus.out_cos), 64'(fcos(ce.ang)));
      end else begin
        chk("no_extra_valid", 64'(bus.out_valid), 64'(0));
      end
    end
  end

  task automatic wait_slot(input int s);
    bit ok = 0;
    for (int i = 0; i < 2 * NCH && !ok; i++) begin
      @(negedge clk);
      if (m_slot == s) ok = 1;
    end
    if (!ok) chk("wait_slot_timeout", 64'(m_slot), 64'(s));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_angle"}, 64'(bus.sc_angle), 64'(0));
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_ch"},    64'(bus.out_ch), 64'(0));
    chk({tag, "_sin"},   64'(bus.out_sin), 64'(0));
    chk({tag, "_cos"},   64'(bus.out_cos), 64'(0));
    chk({tag, "_pend"},  64'(bus.cfg_pend), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  int n, a1;
  bit found;

  initial begin
    bus.cfg_we = 0; bus.cfg_ch = '0; bus.cfg_ftw = '0; bus.cfg_sync = 0; bus.ch_en = '0;
    repeat (2) @(negedge clk);
    chk_zero("rst");

    // Single channel, one step of 0x10000 per frame, wraps after 16 frames.
    bus.ch_en = 4'b0001;
    #2 rst_n = 1'b1;
    wait_slot(1); bus.cfg_we = 1; bus.cfg_ch = 0; bus.cfg_ftw = 32'h1000_0000;
    wait_slot(2); bus.cfg_we = 0;
    chk("t1_pend_set", 64'(bus.cfg_pend), 64'(1));
    wait_slot(0);
    chk("t1_pend_clr", 64'(bus.cfg_pend), 64'(0));
    for (int k = 0; k <= 16; k++) begin
      wait_slot(1);
      chk("t1_angle", 64'(bus.sc_angle), 64'((k * 32'h10000) & 32'hFFFFF));
    end

    // All channels: first-result latency and continuous round-robin output.
    @(negedge clk); #2 rst_n = 1'b0;
    bus.ch_en = 4'hF;
    @(negedge clk); #2 rst_n = 1'b1;
    n = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (bus.out_valid) found = 1;
    end
    chk("t2_first_latency", 64'(n), 64'(2 + SC_LAT));
    chk("t2_first_ch", 64'(bus.out_ch), 64'(0));
    for (int i = 0; i < NCH; i++) begin
      bus.cfg_we = 1; bus.cfg_ch = CW'(i); bus.cfg_ftw = 32'(i + 1) * 32'h1000;
      @(negedge clk);
    end
    bus.cfg_we = 0;
    wait_slot(0); wait_slot(0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t2_cont_valid", 64'(bus.out_valid), 64'(1));
      chk("t2_rr_ch", 64'(bus.out_ch), 64'(((m_slot - 2 - SC_LAT) % NCH + NCH) % NCH));
    end

    // Two writes to ch2, second one in the wrap cycle.
    do_reset();
    bus.ch_en = 4'b0100;
    wait_slot(1); bus.cfg_we = 1; bus.cfg_ch = 2; bus.cfg_ftw = 32'h100;
    wait_slot(2); bus.cfg_we = 0;
    chk("t3_pend_a", 64'(bus.cfg_pend), 64'(1));
    wait_slot(3); bus.cfg_we = 1; bus.cfg_ftw = 32'h200;
    wait_slot(0); bus.cfg_we = 0;
    chk("t3_pend_b", 64'(bus.cfg_pend), 64'(1));
    wait_slot(0);
    chk("t3_pend_c", 64'(bus.cfg_pend), 64'(0));
    for (int j = 0; j < 40; j++) wait_slot(3);
    chk("t3_angle", 64'(bus.sc_angle), 64'(4));

    // Channel 1 disabled for three frames holds its phase.
    bus.ch_en = 4'hF;
    wait_slot(1); bus.cfg_we = 1; bus.cfg_ch = 1; bus.cfg_ftw = 32'h0100_0000;
    wait_slot(2); bus.cfg_we = 0;
    wait_slot(0); wait_slot(0);
    wait_slot(2); a1 = int'(bus.sc_angle);
    wait_slot(0); bus.ch_en = 4'b1101;
    repeat (3) wait_slot(0);
    bus.ch_en = 4'hF;
    wait_slot(2);
    chk("t4_resume", 64'(bus.sc_angle), 64'((a1 + 32'h1000) & 32'hFFFFF));

    // Sync mid-frame: one frame of zero angles, then normal stepping.
    wait_slot(1); bus.cfg_sync = 1;
    wait_slot(2); bus.cfg_sync = 0;
    chk("t5_pend", 64'(bus.cfg_pend), 64'(1));
    wait_slot(0);
    chk("t5_pend_clr", 64'(bus.cfg_pend), 64'(0));
    for (int s = 1; s <= NCH; s++) begin
      wait_slot(s % NCH);
      chk("t5_zero", 64'(bus.sc_angle), 64'(0));
    end
    wait_slot(2);
    chk("t5_step", 64'(bus.sc_angle), 64'(20'h01000));

    // Reset mid-frame with a pending write and tags in flight.
    wait_slot(1); bus.cfg_we = 1; bus.cfg_ch = 1; bus.cfg_ftw = 32'h0200_0000;
    @(negedge clk); bus.cfg_we = 0;
    chk("t6_pend", 64'(bus.cfg_pend), 64'(1));
    #2 rst_n = 1'b0;
    #1 chk_zero("t6_rst");
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 1 + SC_LAT; i++) begin
      @(negedge clk);
      chk("t6_no_valid", 64'(bus.out_valid), 64'(0));
    end
    @(negedge clk);
    chk("t6_first_valid", 64'(bus.out_valid), 64'(1));
    repeat (4) wait_slot(0);
    wait_slot(2);
    chk("t6_write_lost", 64'(bus.sc_angle), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nco_sched.md
NCO_SCHED -- requirements
Module: nco_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, number of time-multiplexed NCO channels (power of 2, 2..16).
REQ-002 SHALL have parameter PHW, default 32, phase accumulator and tuning word width.
REQ-003 SHALL have parameter SC_LAT, default 7, latency in clocks from sc_angle to sc_sin/sc_cos of the attached sincos instance.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port cfg_we  in  1  write strobe for tuning-word shadow register.
REQ-007 SHALL have port cfg_ch  in  log2(NCH)  channel addressed by cfg_we.
REQ-008 SHALL have port cfg_ftw  in  PHW  tuning word written on cfg_we.
REQ-009 SHALL have port cfg_sync  in  1  pulse requesting phase clear of all channels.
REQ-010 SHALL have port ch_en  in  NCH  per-channel enable.
REQ-011 SHALL have port cfg_pend  out  1  high while any shadow write or sync awaits commit.
REQ-012 SHALL have port sc_angle  out  20  angle to sincos, PHW-bit phase truncated to top 20 bits.
REQ-013 SHALL have port sc_sin, sc_cos  in  19 each  sign-magnitude results from sincos.
REQ-014 SHALL have port out_valid  out  1  result valid.
REQ-015 SHALL have port out_ch  out  log2(NCH)  channel of current result.
REQ-016 SHALL have port out_sin, out_cos  out  19 each  registered copies of sc_sin/sc_cos.

Function
REQ-017 SHALL run a slot counter 0..NCH-1 advancing every clock, wrapping NCH-1 -> 0; one frame = NCH clocks.
REQ-018 SHALL, in slot cycle T for channel s with ch_en[s]=1, register sc_angle <= acc[s][PHW-1:PHW-20] (visible at T+1) and update acc[s] <= acc[s] + ftw_act[s] modulo 2^PHW.
REQ-019 SHALL, for ch_en[s]=0, hold acc[s] and sc_angle, and inject no valid tag; re-enable resumes from held phase.
REQ-020 SHALL carry a {valid, channel} tag through an SC_LAT-deep shift register aligned with sc_angle, so out_valid/out_ch/out_sin/out_cos update at T+2+SC_LAT.
REQ-021 SHALL keep out_sin/out_cos unchanged when the emerging tag is invalid; out_valid=0 that cycle.
REQ-022 SHALL write cfg_ftw into shadow[cfg_ch] on cfg_we and set pending; repeated writes before commit: last wins.
REQ-023 SHALL commit all pending shadows to ftw_act on the clock edge where slot wraps NCH-1 -> 0, so every channel in a frame uses a coherent tuning-word set.
REQ-024 SHALL latch cfg_sync as pending and, at the same wrap edge, clear all acc to 0 instead of accumulating; a channel issued in slot NCH-1 on that edge is overwritten by the clear.
REQ-025 SHALL treat cfg_we in the wrap cycle as pending for the following frame, not the current commit; same for cfg_sync.
REQ-026 SHALL drive cfg_pend from registered pending flags; deasserts the cycle after commit unless a new request arrived in the wrap cycle.
REQ-027 SHALL have no backpressure; the sincos pipeline is assumed always ready.

Reset
REQ-028 SHALL on rst_n=0 asynchronously clear slot, all acc, ftw_act, shadows, pending flags, tag pipe, sc_angle, out_valid, out_ch, out_sin, out_cos, cfg_pend to 0.
REQ-029 SHALL resume at slot 0 on the first rising edge after rst_n deassertion; reset mid-frame discards uncommitted writes and in-flight tags.

Verification
REQ-030 SHALL verify: NCH=4, ch_en=0001, write ch0 ftw=0x10000000, wait commit -> sc_angle for ch0 steps 0x00000, 0x10000, 0x20000 ... every 4 clocks, wraps to 0x00000 after 16 frames.
REQ-031 SHALL verify: all channels enabled, ftw 0x1,0x2,0x3,0x4 (x 0x1000) -> out_ch cycles 0,1,2,3, out_valid continuous, first valid exactly 2+SC_LAT clocks after first issue slot.
REQ-032 SHALL verify: two writes to ch2 (0x100, then 0x200) within one frame, second in wrap cycle -> 0x100 committed at that wrap, 0x200 at next wrap; cfg_pend high across both.
REQ-033 SHALL verify: ch_en[1] dropped for 3 frames -> no out_ch=1 results for those slots, acc[1] unchanged, resumed phase continues from held value.
REQ-034 SHALL verify: cfg_sync mid-frame -> all channels issue angle 0x00000 in first frame after wrap, then advance normally.
REQ-035 SHALL verify: rst_n asserted mid-frame with pending write and in-flight tags -> all outputs 0 immediately, no out_valid until a new issue reaches output, pending write lost.
